// File: rtl/reg_bank_sync.sv
// Register bank with one write port, two registered read ports with write bypass,
// an optional hardwired-zero entry and a sequencer that loads a fixed pattern.
module reg_bank_sync #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 0,
  parameter int INIT_BASE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_ptr, init_ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd1_next, rd2_next;
  logic              zero_en;
  logic              wr_ok;

  assign zero_en = (ZERO_REG != 0);
  assign wr_ok   = wr_en && !(zero_en && (write_reg == '0));

  // Read mux: hardwired zero wins over bypass, bypass wins over the array.
  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] arr_data);
    if (zero_en && (addr == '0))
      return '0;
    else if (wr_ok && (write_reg == addr))
      return write_data;
    else
      return arr_data;
  endfunction

  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    mem_we        = 1'b0;
    mem_addr      = write_reg;
    mem_wdata     = write_data;
    rd1_next      = '0;
    rd2_next      = '0;
    unique case (state)
      ST_INIT: begin
        mem_we        = 1'b1;
        mem_addr      = init_ptr;
        mem_wdata     = (zero_en && (init_ptr == '0)) ? '0
                        : DATA_W'(INIT_BASE) + DATA_W'(init_ptr);
        init_ptr_next = init_ptr + ADDR_W'(1);
        if (init_ptr == LAST_PTR)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        // The write in a re-init cycle still lands; the sequence overwrites it later.
        mem_we = wr_ok;
        if (init_req) begin
          state_next = ST_INIT;
        end else begin
          rd1_next = read_sel(read_reg1, mem[read_reg1]);
          rd2_next = read_sel(read_reg2, mem[read_reg2]);
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_ptr   <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      ready      <= 1'b0;
    end else begin
      state      <= state_next;
      init_ptr   <= init_ptr_next;
      read_data1 <= rd1_next;
      read_data2 <= rd2_next;
      ready      <= (state_next == ST_RUN);
    end
  end

endmodule

// File: tb/tb_reg_bank_sync.sv
// Scoreboard bench for reg_bank_sync: one instance with defaults and one with the
// hardwired-zero entry enabled, both driven by the same stimulus.
module tb_reg_bank_sync;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ireq;
  } stim_t;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] z1;
    logic [31:0] z2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [31:0] read_data1, read_data2, z_read_data1, z_read_data2;
  logic        ready, z_ready;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg_bank_sync #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .INIT_BASE(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en),
    .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .ready(ready)
  );

  reg_bank_sync #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .INIT_BASE(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en),
    .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(z_read_data1), .read_data2(z_read_data2), .ready(z_ready)
  );

  // Drives one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input stim_t s);
    wr_en      = s.we;
    write_reg  = s.wa;
    write_data = s.wd;
    read_reg1  = s.r1;
    read_reg2  = s.r2;
    init_req   = s.ireq;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    init_req = 1'b0;
  endtask

  // Counts edges until both instances report ready, optionally pulsing init_req.
  task automatic wait_ready(input int pulse_at, output int edges, output bit leak);
    edges = 0;
    leak  = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n == pulse_at) init_req = 1'b1;
      @(posedge clk);
      #1;
      init_req = 1'b0;
      edges = n;
      if (read_data1 !== 32'd0 || read_data2 !== 32'd0 ||
          z_read_data1 !== 32'd0 || z_read_data2 !== 32'd0)
        leak = 1'b1;
      if (ready === 1'b1 && z_ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    stim_t st[2];
    exp_t  ex[2];
    exp_t  e;
    int    edges;
    bit    leak;
    #2 rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (ready !== 1'b0 || z_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset ready: got %b/%b expected 0", ready, z_ready);
    end
    if (read_data1 !== 32'd0 || z_read_data1 !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL reset rd1: got %h/%h expected 0", read_data1, z_read_data1);
    end
    if (read_data2 !== 32'd0 || z_read_data2 !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL reset rd2: got %h/%h expected 0", read_data2, z_read_data2);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(0, edges, leak);
    tests_run += 2;
    if (edges !== 32) begin
      tests_failed++; $display("[TB] FAIL reset init_edges: got %0d expected 32", edges);
    end
    if (leak) begin
      tests_failed++; $display("[TB] FAIL reset init_reads: got non-zero expected 0");
    end
    st[0] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0};   ex[0] = '{32'd1, 32'd6, 32'd0, 32'd6};
    st[1] = '{1'b0, 5'd0, 32'd0, 5'd31, 5'd31, 1'b0}; ex[1] = '{32'd32, 32'd32, 32'd32, 32'd32};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      applyStimulus(st[i]);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL init_read rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL init_read rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL init_read zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL init_read zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
    end
  endtask

  task automatic test_write_read();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd1, 5'd1, 1'b0}; ex[0] = '{32'd2, 32'd2, 32'd2, 32'd2};
    st[1] = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd1, 1'b0};        ex[1] = '{32'hDEADBEEF, 32'd2, 32'hDEADBEEF, 32'd2};
    st[2] = '{1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 1'b0}; ex[2] = '{4{32'h12345678}};
    st[3] = '{1'b0, 5'd0, 32'd0, 5'd9, 5'd7, 1'b0};        ex[3] = '{32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      applyStimulus(st[i]);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL write_bypass rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL write_bypass rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL write_bypass zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL write_bypass zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st[0] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0}; ex[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    st[1] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0};        ex[1] = '{32'hFFFFFFFF, 32'd4, 32'd0, 32'd4};
    st[2] = '{1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 1'b0};       ex[2] = '{32'hFFFFFFFF, 32'h55, 32'd0, 32'h55};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      applyStimulus(st[i]);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL zero_reg rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL zero_reg rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL zero_reg zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL zero_reg zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    logic [31:0] d, d_prev;
    d_prev = 32'd21;
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE0000 + 32'(i) * 32'h111;
      s = '{1'b1, 5'(10 + i), d, 5'(10 + i), (i == 0) ? 5'd20 : 5'(9 + i), 1'b0};
      sb.push_back('{d, d_prev, d, d_prev});
      applyStimulus(s);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL back_to_back rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL back_to_back rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL back_to_back zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL back_to_back zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
      d_prev = d;
    end
  endtask

  task automatic test_init_req();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    int    edges;
    bit    leak;
    st[0] = '{1'b1, 5'd2, 32'hAA, 5'd2, 5'd0, 1'b0};       ex[0] = '{32'hAA, 32'hFFFFFFFF, 32'hAA, 32'd0};
    st[1] = '{1'b1, 5'd3, 32'hBB, 5'd2, 5'd2, 1'b1};       ex[1] = '{4{32'd0}};
    st[2] = '{1'b0, 5'd0, 32'd0, 5'd2, 5'd3, 1'b0};        ex[2] = '{32'd3, 32'd4, 32'd3, 32'd4};
    st[3] = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd12, 1'b0};       ex[3] = '{32'd1, 32'd13, 32'd0, 32'd13};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      applyStimulus(st[i]);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL init_req rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL init_req rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL init_req zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL init_req zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
      if (i == 1) begin
        tests_run += 3;
        if (ready !== 1'b0 || z_ready !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL init_req ready_drop: got %b/%b expected 0", ready, z_ready);
        end
        // A second request mid-sequence must not restart the pointer.
        wait_ready(5, edges, leak);
        if (edges !== 32) begin
          tests_failed++; $display("[TB] FAIL init_req init_edges: got %0d expected 32", edges);
        end
        if (leak) begin
          tests_failed++; $display("[TB] FAIL init_req init_reads: got non-zero expected 0");
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[2];
    exp_t  ex[2];
    exp_t  e;
    int    edges;
    bit    leak;
    st[0] = '{1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0}; ex[0] = '{32'd6, 32'd32, 32'd6, 32'd32};
    st[1] = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0};  ex[1] = '{32'd8, 32'd1, 32'd8, 32'd0};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      applyStimulus(st[i]);
      e = sb.pop_front();
      tests_run += 4;
      if (read_data1 !== e.d1) begin tests_failed++; $display("[TB] FAIL reset_mid rd1[%0d]: got %h expected %h", i, read_data1, e.d1); end
      if (read_data2 !== e.d2) begin tests_failed++; $display("[TB] FAIL reset_mid rd2[%0d]: got %h expected %h", i, read_data2, e.d2); end
      if (z_read_data1 !== e.z1) begin tests_failed++; $display("[TB] FAIL reset_mid zrd1[%0d]: got %h expected %h", i, z_read_data1, e.z1); end
      if (z_read_data2 !== e.z2) begin tests_failed++; $display("[TB] FAIL reset_mid zrd2[%0d]: got %h expected %h", i, z_read_data2, e.z2); end
      if (i == 0) begin
        #2 rst_n = 1'b0;
        #1;
        tests_run += 3;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
          tests_failed++; $display("[TB] FAIL reset_mid async_rd: got %h/%h expected 0", read_data1, read_data2);
        end
        if (ready !== 1'b0 || z_ready !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL reset_mid async_ready: got %b/%b expected 0", ready, z_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(0, edges, leak);
        if (edges !== 32) begin
          tests_failed++; $display("[TB] FAIL reset_mid init_edges: got %0d expected 32", edges);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_back_to_back();
    test_init_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
